// File: rtl/hermes_local_injector.sv
// Hermes LOCAL-port packet injector: header, size, payload flits
// with credit flow control through one registered output slot.
module hermes_local_injector #(
    parameter int FLIT_SIZE   = 32,
    parameter int MAX_PAYLOAD = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [15:0]          req_target_i,
    input  logic [15:0]          req_size_i,
    input  logic                 pl_valid_i,
    output logic                 pl_ready_o,
    input  logic [FLIT_SIZE-1:0] pl_data_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 busy_o,
    output logic                 pkt_sent_o,
    output logic                 err_size_o
);

    typedef enum logic [1:0] {
        IDLE,
        SIZE,
        PAYLOAD
    } state_t;

    localparam logic [15:0] MAX_SZ = 16'(MAX_PAYLOAD);

    state_t               state;
    logic [15:0]          size_q;
    logic [15:0]          cnt;
    logic                 last_q;
    logic                 tx_q;
    logic [FLIT_SIZE-1:0] data_q;
    logic                 pkt_q;
    logic                 err_q;

    logic slot_free;
    logic req_hs;
    logic pl_hs;
    logic size_ok;

    assign slot_free   = !tx_q || credit_i;
    assign req_ready_o = (state == IDLE) && slot_free;
    assign pl_ready_o  = (state == PAYLOAD) && slot_free;
    assign req_hs      = req_valid_i && req_ready_o;
    assign pl_hs       = pl_valid_i && pl_ready_o;
    assign size_ok     = (req_size_i != 16'd0) && (req_size_i <= MAX_SZ);

    assign tx_o       = tx_q;
    assign data_o     = data_q;
    assign busy_o     = (state != IDLE) || tx_q;
    assign pkt_sent_o = pkt_q;
    assign err_size_o = err_q;

    // Packet FSM driving the output slot, counters and status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            size_q <= '0;
            cnt    <= '0;
            last_q <= 1'b0;
            tx_q   <= 1'b0;
            data_q <= '0;
            pkt_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pkt_q <= tx_q && credit_i && last_q;
            err_q <= 1'b0;
            // a taken flit empties the slot unless reloaded below
            if (slot_free) begin
                tx_q   <= 1'b0;
                last_q <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (req_hs) begin
                        if (size_ok) begin
                            tx_q   <= 1'b1;
                            data_q <= {{(FLIT_SIZE-16){1'b0}}, req_target_i};
                            size_q <= req_size_i;
                            cnt    <= req_size_i;
                            state  <= SIZE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SIZE: begin
                    if (slot_free) begin
                        tx_q   <= 1'b1;
                        data_q <= {{(FLIT_SIZE-16){1'b0}}, size_q};
                        state  <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (pl_hs) begin
                        tx_q   <= 1'b1;
                        data_q <= pl_data_i;
                        cnt    <= cnt - 16'd1;
                        if (cnt == 16'd1) begin
                            last_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hermes_local_injector.sv
// Directed bench for hermes_local_injector: a per-cycle vector
// table plus hand-written multi-cycle sequences.
module tb_hermes_local_injector;

    localparam int FW = 32;
    localparam int MP = 256;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [15:0]   req_target_i;
    logic [15:0]   req_size_i;
    logic          pl_valid_i;
    logic          pl_ready_o;
    logic [FW-1:0] pl_data_i;
    logic          tx_o;
    logic          credit_i;
    logic [FW-1:0] data_o;
    logic          busy_o;
    logic          pkt_sent_o;
    logic          err_size_o;

    always #5 clk = ~clk;

    hermes_local_injector #(.FLIT_SIZE(FW), .MAX_PAYLOAD(MP)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_target_i(req_target_i),
        .req_size_i  (req_size_i),
        .pl_valid_i  (pl_valid_i),
        .pl_ready_o  (pl_ready_o),
        .pl_data_i   (pl_data_i),
        .tx_o        (tx_o),
        .credit_i    (credit_i),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .pkt_sent_o  (pkt_sent_o),
        .err_size_o  (err_size_o)
    );

    typedef struct {
        logic        rv;
        logic [15:0] tg;
        logic [15:0] sz;
        logic        pv;
        logic [31:0] pd;
        logic        cr;
        logic        tx;
        logic [31:0] d;
        logic        ps;
        logic        bz;
        logic        rr;
        logic        pr;
    } vec_t;

    vec_t        tv[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cycle_n = 0;
    int          pkt_cnt = 0;
    int          err_cnt = 0;
    int          gap_cnt = 0;
    logic [31:0] flits[$];
    int          fcyc[$];
    logic [31:0] ef[$];
    logic [31:0] words[8];
    int          idx;
    logic        rhs;
    logic        ok;

    localparam logic [31:0] A = 32'hAAAA_0001;
    localparam logic [31:0] B = 32'hBBBB_0002;
    localparam logic [31:0] C = 32'hCCCC_0003;

    // Transfer monitor: records every flit taken by the router
    always @(negedge clk) begin
        cycle_n++;
        if (!rst_i) begin
            if (tx_o && credit_i) begin
                flits.push_back(data_o);
                fcyc.push_back(cycle_n);
            end
            if (pkt_sent_o) pkt_cnt++;
            if (err_size_o) err_cnt++;
            if (busy_o && !tx_o) gap_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rv, input logic [15:0] tg,
                       input logic [15:0] sz, input logic pv,
                       input logic [31:0] pd, input logic cr,
                       input logic tx, input logic [31:0] d,
                       input logic ps, input logic bz,
                       input logic rr, input logic pr);
        vec_t v;
        v.rv = rv; v.tg = tg; v.sz = sz; v.pv = pv; v.pd = pd;
        v.cr = cr; v.tx = tx; v.d = d; v.ps = ps; v.bz = bz;
        v.rr = rr; v.pr = pr;
        tv.push_back(v);
    endtask

    task automatic cyc();
        @(negedge clk);
        rhs = req_valid_i && req_ready_o;
        if (pl_valid_i && pl_ready_o && idx < 7) idx++;
        @(posedge clk);
        #1;
        pl_data_i = words[idx];
    endtask

    task automatic clr();
        flits.delete();
        fcyc.delete();
        pkt_cnt = 0;
        err_cnt = 0;
        gap_cnt = 0;
    endtask

    task automatic load_words(input logic [31:0] base);
        for (int i = 0; i < 8; i++) words[i] = base + 32'(i);
        idx = 0;
        pl_data_i = words[0];
    endtask

    task automatic chk_flits(input string nm);
        chk($sformatf("%s count", nm), 32'(flits.size()), 32'(ef.size()));
        for (int i = 0; i < ef.size(); i++)
            if (i < flits.size())
                chk($sformatf("%s flit%0d", nm, i), flits[i], ef[i]);
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        req_target_i = '0;
        req_size_i = '0;
        pl_valid_i = 1'b0;
        pl_data_i = '0;
        credit_i = 1'b1;
        idx = 0;
        for (int i = 0; i < 8; i++) words[i] = '0;

        // basic packet, credit always 1
        add(1, 16'h0102, 3, 0, 0, 1,  0, 0,        0, 0, 1, 0);
        add(0, 0, 0,        1, A, 1,  1, 32'h102,  0, 1, 0, 0);
        add(0, 0, 0,        1, A, 1,  1, 32'd3,    0, 1, 0, 1);
        add(0, 0, 0,        1, B, 1,  1, A,        0, 1, 0, 1);
        add(0, 0, 0,        1, C, 1,  1, B,        0, 1, 0, 1);
        add(0, 0, 0,        0, 0, 1,  1, C,        0, 1, 1, 0);
        add(0, 0, 0,        0, 0, 1,  0, 0,        1, 0, 1, 0);
        add(0, 0, 0,        0, 0, 1,  0, 0,        0, 0, 1, 0);
        // credit stall on the size flit for 4 cycles
        add(1, 16'h0102, 3, 0, 0, 1,  0, 0,        0, 0, 1, 0);
        add(0, 0, 0,        1, A, 1,  1, 32'h102,  0, 1, 0, 0);
        add(0, 0, 0,        1, A, 0,  1, 32'd3,    0, 1, 0, 0);
        add(0, 0, 0,        1, A, 0,  1, 32'd3,    0, 1, 0, 0);
        add(0, 0, 0,        1, A, 0,  1, 32'd3,    0, 1, 0, 0);
        add(0, 0, 0,        1, A, 0,  1, 32'd3,    0, 1, 0, 0);
        add(0, 0, 0,        1, A, 1,  1, 32'd3,    0, 1, 0, 1);
        add(0, 0, 0,        1, B, 1,  1, A,        0, 1, 0, 1);
        add(0, 0, 0,        1, C, 1,  1, B,        0, 1, 0, 1);
        add(0, 0, 0,        0, 0, 1,  1, C,        0, 1, 1, 0);
        add(0, 0, 0,        0, 0, 1,  0, 0,        1, 0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        @(negedge clk);
        chk("rst tx", 32'(tx_o), 0);
        chk("rst data", data_o, 0);
        chk("rst busy", 32'(busy_o), 0);
        chk("rst pkt_sent", 32'(pkt_sent_o), 0);
        chk("rst err", 32'(err_size_o), 0);
        chk("rst req_ready", 32'(req_ready_o), 1);
        chk("rst pl_ready", 32'(pl_ready_o), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            req_valid_i  = tv[i].rv;
            req_target_i = tv[i].tg;
            req_size_i   = tv[i].sz;
            pl_valid_i   = tv[i].pv;
            pl_data_i    = tv[i].pd;
            credit_i     = tv[i].cr;
            @(negedge clk);
            chk($sformatf("v%0d tx", i), 32'(tx_o), 32'(tv[i].tx));
            if (tv[i].tx)
                chk($sformatf("v%0d data", i), data_o, tv[i].d);
            chk($sformatf("v%0d pkt_sent", i), 32'(pkt_sent_o), 32'(tv[i].ps));
            chk($sformatf("v%0d busy", i), 32'(busy_o), 32'(tv[i].bz));
            chk($sformatf("v%0d req_ready", i), 32'(req_ready_o), 32'(tv[i].rr));
            chk($sformatf("v%0d pl_ready", i), 32'(pl_ready_o), 32'(tv[i].pr));
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        pl_valid_i = 1'b0;
        credit_i = 1'b1;

        // payload gaps: valid low for 2 cycles after word 1
        clr();
        load_words(32'hD000_0000);
        req_valid_i = 1'b1;
        req_target_i = 16'h0304;
        req_size_i = 16'd4;
        pl_valid_i = 1'b1;
        cyc();
        req_valid_i = 1'b0;
        repeat (3) cyc();
        pl_valid_i = 1'b0;
        repeat (2) cyc();
        pl_valid_i = 1'b1;
        repeat (8) cyc();
        pl_valid_i = 1'b0;
        ef = '{32'h304, 32'd4, 32'hD000_0000, 32'hD000_0001,
               32'hD000_0002, 32'hD000_0003};
        chk_flits("gap");
        chk("gap pkt_sent count", 32'(pkt_cnt), 1);
        chk("gap tx-low cycles", 32'(gap_cnt), 2);
        chk("gap busy end", 32'(busy_o), 0);

        // illegal sizes: 0 and MAX_PAYLOAD+1
        clr();
        req_valid_i = 1'b1;
        req_target_i = 16'h0707;
        req_size_i = 16'd0;
        cyc();
        req_valid_i = 1'b0;
        @(negedge clk);
        chk("err0 pulse", 32'(err_size_o), 1);
        chk("err0 tx", 32'(tx_o), 0);
        chk("err0 busy", 32'(busy_o), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("err0 width", 32'(err_size_o), 0);
        @(posedge clk);
        #1;
        req_valid_i = 1'b1;
        req_size_i = 16'(MP + 1);
        cyc();
        req_valid_i = 1'b0;
        repeat (3) cyc();
        chk("err pulse cycles", 32'(err_cnt), 2);
        chk("err no flits", 32'(flits.size()), 0);

        clr();
        load_words(32'hE000_0000);
        req_valid_i = 1'b1;
        req_target_i = 16'h0506;
        req_size_i = 16'd1;
        pl_valid_i = 1'b1;
        cyc();
        req_valid_i = 1'b0;
        repeat (6) cyc();
        pl_valid_i = 1'b0;
        ef = '{32'h506, 32'd1, 32'hE000_0000};
        chk_flits("legal1");
        chk("legal1 pkt_sent", 32'(pkt_cnt), 1);

        // back-to-back size-1 packets
        clr();
        load_words(32'hF000_0000);
        req_valid_i = 1'b1;
        req_target_i = 16'h0A0B;
        req_size_i = 16'd1;
        pl_valid_i = 1'b1;
        cyc();
        chk("b2b first accept", 32'(rhs), 1);
        req_target_i = 16'h0C0D;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            cyc();
            ok = rhs;
        end
        chk("b2b second accept", 32'(ok), 1);
        req_valid_i = 1'b0;
        repeat (6) cyc();
        pl_valid_i = 1'b0;
        ef = '{32'hA0B, 32'd1, 32'hF000_0000,
               32'hC0D, 32'd1, 32'hF000_0001};
        chk_flits("b2b");
        chk("b2b pkt_sent count", 32'(pkt_cnt), 2);
        if (fcyc.size() == 6)
            chk("b2b span", 32'(fcyc[5] - fcyc[0]), 5);

        // reset during payload word 2
        clr();
        load_words(32'h1100_0000);
        req_valid_i = 1'b1;
        req_target_i = 16'h0101;
        req_size_i = 16'd5;
        pl_valid_i = 1'b1;
        cyc();
        req_valid_i = 1'b0;
        repeat (4) cyc();
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid word2", data_o, 32'h1100_0002);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        pl_valid_i = 1'b0;
        @(negedge clk);
        chk("mid rst tx", 32'(tx_o), 0);
        chk("mid rst data", data_o, 0);
        chk("mid rst busy", 32'(busy_o), 0);
        chk("mid rst req_ready", 32'(req_ready_o), 1);
        @(posedge clk);
        #1;
        repeat (3) cyc();
        chk("mid rst no pkt_sent", 32'(pkt_cnt), 0);

        clr();
        load_words(32'h2200_0000);
        req_valid_i = 1'b1;
        req_target_i = 16'h0202;
        req_size_i = 16'd2;
        pl_valid_i = 1'b1;
        cyc();
        req_valid_i = 1'b0;
        repeat (7) cyc();
        pl_valid_i = 1'b0;
        ef = '{32'h202, 32'd2, 32'h2200_0000, 32'h2200_0001};
        chk_flits("fresh");
        chk("fresh pkt_sent", 32'(pkt_cnt), 1);
        chk("fresh busy end", 32'(busy_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
